l2_trace_cmd_dispatcher: RTL and testbench

//  Upstream feeder for the L2 cache simulator: accepts trace commands (opcode, address), buffers them in a FIFO,
//  and issues them one at a time to the cache over a req/ack handshake. Executes the clear (8) and print (9)

---
 rtl/l2_trace_cmd_dispatcher.sv | 177 +++++++++++++++++
 tb/tb_l2_trace_cmd_dispatcher.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_trace_cmd_dispatcher.sv
// ---------------------------------------------------------------------------
// l2_trace_cmd_dispatcher
//
// Upstream feeder for the L2 cache simulator. Trace commands (opcode, address)
// are buffered in a first-word-fall-through FIFO. They are dispatched one at a
// time: opcodes 0..6 go to the cache over a req/ack handshake, 8 (clear) and
// 9 (print) are executed locally as one-cycle pulses, and all other opcodes
// are dropped and counted. The block also keeps L1-side read/write/hit/miss
// statistics, taken from the cache's hit response.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       trace command handshake (in_ready = FIFO not full)
//   in_op, in_addr          trace opcode (0..15) and address
//   cache_req               command presented to the cache (held until ack)
//   cache_op, cache_addr    command to the cache, stable while cache_req=1
//   cache_ack, cache_hit    cache completion and hit(1)/miss(0)
//   clear_o, print_o        one-cycle clear / print pulses to the cache
//   rd_cnt, wr_cnt          L1 reads (ops 0, 2) and writes (op 1)
//   hit_cnt, miss_cnt       hit / miss outcome of ops 0..2
//   err_cnt                 dropped illegal opcodes (7, 10..15)
//   busy                    FSM not idle or FIFO non-empty
// ---------------------------------------------------------------------------
module l2_trace_cmd_dispatcher #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              cache_req,
  output logic [2:0]        cache_op,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_ack,
  input  logic              cache_hit,
  output logic              clear_o,
  output logic              print_o,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_CLR  = 2'd2;
  localparam logic [1:0] S_PRT  = 2'd3;

  typedef struct packed {
    logic [3:0]        op;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [1:0]       state;
  cmd_t             head;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // -------------------------------------------------------------------------
  // Command FIFO (first-word-fall-through)
  // -------------------------------------------------------------------------
  assign fifo_empty = (count == '0);
  assign in_ready   = (count != (PTR_W+1)'(DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign head       = mem[rd_ptr];

  // NOTE: the storage array has no reset; count alone says which entries are
  // valid, so clearing it would only cost flops and reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd_t'{op: in_op, addr: in_addr};
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Dispatch FSM and statistics
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cache_op   <= '0;
      cache_addr <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            if (head.op <= 4'd6) begin
              cache_op   <= head.op[2:0];
              cache_addr <= head.addr;
              state      <= S_REQ;
            end else if (head.op == 4'd8) begin
              state <= S_CLR;
            end else if (head.op == 4'd9) begin
              state <= S_PRT;
            end else begin
              err_cnt <= sat_inc(err_cnt);
            end
          end
        end
        S_REQ: begin
          if (cache_ack) begin
            if (cache_op == 3'd0 || cache_op == 3'd2) rd_cnt <= sat_inc(rd_cnt);
            if (cache_op == 3'd1)                     wr_cnt <= sat_inc(wr_cnt);
            // Snoops (3..6) complete without touching the statistics.
            if (cache_op <= 3'd2) begin
              if (cache_hit) hit_cnt  <= sat_inc(hit_cnt);
              else           miss_cnt <= sat_inc(miss_cnt);
            end
            state <= S_IDLE;
          end
        end
        S_CLR: begin
          // The cache is being wiped, so L1-side stats restart; err_cnt is
          // about the trace itself and survives.
          rd_cnt   <= '0;
          wr_cnt   <= '0;
          hit_cnt  <= '0;
          miss_cnt <= '0;
          state    <= S_IDLE;
        end
        default: begin // S_PRT
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Decoded from state so an async reset drops them immediately.
  assign cache_req = (state == S_REQ);
  assign clear_o   = (state == S_CLR);
  assign print_o   = (state == S_PRT);
  assign busy      = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_l2_trace_cmd_dispatcher.sv
// ---------------------------------------------------------------------------
// Self-checking bench for l2_trace_cmd_dispatcher. Cache commands expected
// from the dispatcher are queued as they are pushed and compared when the
// dispatcher raises cache_req; a small statistics model tracks the counters.
// ---------------------------------------------------------------------------
module tb_l2_trace_cmd_dispatcher;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 32;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [ADDR_W-1:0] in_addr;
  logic              cache_req;
  logic [2:0]        cache_op;
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_ack;
  logic              cache_hit;
  logic              clear_o;
  logic              print_o;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic              busy;

  l2_trace_cmd_dispatcher #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_addr   (in_addr),
    .cache_req (cache_req),
    .cache_op  (cache_op),
    .cache_addr(cache_addr),
    .cache_ack (cache_ack),
    .cache_hit (cache_hit),
    .clear_o   (clear_o),
    .print_o   (print_o),
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]        op;
    logic [ADDR_W-1:0] addr;
  } exp_cmd_t;

  exp_cmd_t sb[$];

  int passed = 0;
  int total  = 0;

  logic [CNT_W-1:0] exp_rd   = '0;
  logic [CNT_W-1:0] exp_wr   = '0;
  logic [CNT_W-1:0] exp_hit  = '0;
  logic [CNT_W-1:0] exp_miss = '0;
  logic [CNT_W-1:0] exp_err  = '0;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one command for one cycle; record what the dispatcher should do.
  task automatic push(input logic [3:0] op, input logic [ADDR_W-1:0] addr,
                      output bit accepted);
    exp_cmd_t e;
    in_valid = 1'b1;
    in_op    = op;
    in_addr  = addr;
    accepted = in_ready;
    tick();
    in_valid = 1'b0;
    if (accepted) begin
      if (op <= 4'd6) begin
        e.op   = op[2:0];
        e.addr = addr;
        sb.push_back(e);
      end else if (op != 4'd8 && op != 4'd9) begin
        exp_err = exp_err + 1;
      end
    end
  endtask

  // Cache responder: wait for a request, compare it with the scoreboard
  // head, hold for 'delay' cycles, then ack with the given hit flag.
  task automatic serve(input bit hit, input int delay);
    exp_cmd_t e;
    int waited;
    waited = 0;
    while (cache_req !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    total++;
    if (cache_req !== 1'b1) begin
      $display("FAIL req_timeout: cache_req=%b after %0d cycles, required 1", cache_req, waited);
      return;
    end
    passed++;
    total++;
    if (sb.size() == 0) begin
      $display("FAIL unexpected_req: op=%0d addr=%h with empty scoreboard", cache_op, cache_addr);
      return;
    end
    e = sb.pop_front();
    if ({cache_op, cache_addr} !== {e.op, e.addr})
      $display("FAIL req_cmd: got op=%0d addr=%h, required op=%0d addr=%h",
               cache_op, cache_addr, e.op, e.addr);
    else passed++;
    if (delay > 0) begin
      repeat (delay) tick();
      total++;
      if ({cache_req, cache_op, cache_addr} !== {1'b1, e.op, e.addr})
        $display("FAIL req_hold: got req=%b op=%0d addr=%h, required req=1 op=%0d addr=%h",
                 cache_req, cache_op, cache_addr, e.op, e.addr);
      else passed++;
    end
    cache_ack = 1'b1;
    cache_hit = hit;
    tick();
    cache_ack = 1'b0;
    cache_hit = 1'b0;
    total++;
    if (cache_req !== 1'b0)
      $display("FAIL req_drop: cache_req=%b after ack, required 0", cache_req);
    else passed++;
    if (e.op == 3'd0 || e.op == 3'd2) exp_rd = exp_rd + 1;
    if (e.op == 3'd1)                 exp_wr = exp_wr + 1;
    if (e.op <= 3'd2) begin
      if (hit) exp_hit  = exp_hit + 1;
      else     exp_miss = exp_miss + 1;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_addr   = '0;
    cache_ack = 1'b0;
    cache_hit = 1'b0;
    #1;
    total++;
    if ({in_ready, busy, cache_req, clear_o, print_o} !== 5'b10000)
      $display("FAIL reset_ctrl: ready/busy/req/clr/prt=%b, required 10000",
               {in_ready, busy, cache_req, clear_o, print_o});
    else passed++;
    total++;
    if ({cache_op, cache_addr, rd_cnt, wr_cnt, hit_cnt, miss_cnt, err_cnt} !== '0)
      $display("FAIL reset_data: op=%0d addr=%h rd=%0d wr=%0d hit=%0d miss=%0d err=%0d, required all 0",
               cache_op, cache_addr, rd_cnt, wr_cnt, hit_cnt, miss_cnt, err_cnt);
    else passed++;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    bit acc;
    push(4'd0, 32'h0000_1040, acc);
    total++;
    if ({cache_req, busy} !== 2'b01)
      $display("FAIL latency_early: req/busy=%b one cycle after push, required 01", {cache_req, busy});
    else passed++;
    tick();
    total++;
    if (cache_req !== 1'b1)
      $display("FAIL latency_req: cache_req=%b two cycles after push, required 1", cache_req);
    else passed++;
    serve(1'b0, 2);
    total++;
    if ({rd_cnt, wr_cnt, hit_cnt, miss_cnt, err_cnt} !== {32'd1, 32'd0, 32'd0, 32'd1, 32'd0})
      $display("FAIL single_read_cnt: rd=%0d wr=%0d hit=%0d miss=%0d err=%0d, required 1 0 0 1 0",
               rd_cnt, wr_cnt, hit_cnt, miss_cnt, err_cnt);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit acc;
    push(4'd1, 32'h0000_2000, acc);
    push(4'd2, 32'h0000_2000, acc);
    push(4'd3, 32'h0000_2000, acc);
    serve(1'b1, 0);
    tick();
    total++;
    if (cache_req !== 1'b1)
      $display("FAIL b2b_spacing: cache_req=%b one cycle after drop, required 1", cache_req);
    else passed++;
    serve(1'b1, 0);
    serve(1'b1, 0);
    // Op 3 is a snoop: statistics reflect only the write and the read.
    total++;
    if ({rd_cnt, wr_cnt, hit_cnt, miss_cnt} !== {32'd2, 32'd1, 32'd2, 32'd1})
      $display("FAIL b2b_cnt: rd=%0d wr=%0d hit=%0d miss=%0d, required 2 1 2 1",
               rd_cnt, wr_cnt, hit_cnt, miss_cnt);
    else passed++;
  endtask

  task automatic test_backpressure();
    bit acc;
    int n_acc;
    n_acc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i == DEPTH + 1) begin
        total++;
        if (in_ready !== 1'b0)
          $display("FAIL full_ready: in_ready=%b with FIFO full, required 0", in_ready);
        else passed++;
      end
      push(4'(i % 3), 32'h0000_3000 + 32'(i * 4), acc);
      if (acc) n_acc++;
    end
    total++;
    if (n_acc !== DEPTH + 1)
      $display("FAIL accepted_count: accepted %0d, required %0d", n_acc, DEPTH + 1);
    else passed++;
    for (int i = 0; i < DEPTH + 1; i++) serve(i[0], 0);
    repeat (3) tick();
    total++;
    if ({cache_req, busy, in_ready} !== 3'b001)
      $display("FAIL drain_idle: req/busy/ready=%b, required 001 (extra push must be lost)",
               {cache_req, busy, in_ready});
    else passed++;
    total++;
    if ({rd_cnt, wr_cnt, hit_cnt, miss_cnt} !== {exp_rd, exp_wr, exp_hit, exp_miss})
      $display("FAIL drain_cnt: rd=%0d wr=%0d hit=%0d miss=%0d, required %0d %0d %0d %0d",
               rd_cnt, wr_cnt, hit_cnt, miss_cnt, exp_rd, exp_wr, exp_hit, exp_miss);
    else passed++;
  endtask

  task automatic test_clear_print();
    bit acc;
    int highs;
    push(4'd8, 32'h0, acc);
    highs = 0;
    repeat (6) begin
      if (clear_o === 1'b1) highs++;
      tick();
    end
    total++;
    if (highs !== 1)
      $display("FAIL clear_pulse: clear_o high %0d cycles, required 1", highs);
    else passed++;
    exp_rd = '0; exp_wr = '0; exp_hit = '0; exp_miss = '0;
    total++;
    if ({rd_cnt, wr_cnt, hit_cnt, miss_cnt, err_cnt} !== {exp_rd, exp_wr, exp_hit, exp_miss, exp_err})
      $display("FAIL clear_cnt: rd=%0d wr=%0d hit=%0d miss=%0d err=%0d, required 0 0 0 0 %0d",
               rd_cnt, wr_cnt, hit_cnt, miss_cnt, err_cnt, exp_err);
    else passed++;
    // Give the print something to leave untouched.
    push(4'd0, 32'h0000_0100, acc);
    serve(1'b1, 0);
    push(4'd9, 32'h0, acc);
    highs = 0;
    repeat (6) begin
      if (print_o === 1'b1) highs++;
      tick();
    end
    total++;
    if (highs !== 1 || clear_o !== 1'b0)
      $display("FAIL print_pulse: print_o high %0d cycles clear_o=%b, required 1 and 0", highs, clear_o);
    else passed++;
    total++;
    if ({rd_cnt, hit_cnt} !== {exp_rd, exp_hit})
      $display("FAIL print_cnt: rd=%0d hit=%0d, required %0d %0d", rd_cnt, hit_cnt, exp_rd, exp_hit);
    else passed++;
  endtask

  task automatic test_illegal();
    bit acc;
    int reqs;
    push(4'd7, 32'h0000_0700, acc);
    push(4'd15, 32'h0000_0F00, acc);
    reqs = 0;
    repeat (6) begin
      if (cache_req === 1'b1) reqs++;
      tick();
    end
    // Stray ack while idle must not move any counter.
    cache_ack = 1'b1;
    cache_hit = 1'b1;
    tick();
    cache_ack = 1'b0;
    cache_hit = 1'b0;
    total++;
    if (reqs !== 0)
      $display("FAIL illegal_req: cache_req high %0d cycles, required 0", reqs);
    else passed++;
    total++;
    if ({rd_cnt, wr_cnt, hit_cnt, miss_cnt, err_cnt} !== {exp_rd, exp_wr, exp_hit, exp_miss, 32'd2})
      $display("FAIL illegal_cnt: rd=%0d wr=%0d hit=%0d miss=%0d err=%0d, required %0d %0d %0d %0d 2",
               rd_cnt, wr_cnt, hit_cnt, miss_cnt, err_cnt, exp_rd, exp_wr, exp_hit, exp_miss);
    else passed++;
    push(4'd0, 32'h0000_4444, acc);
    serve(1'b0, 1);
    total++;
    if ({rd_cnt, miss_cnt, err_cnt} !== {exp_rd, exp_miss, exp_err})
      $display("FAIL after_illegal_cnt: rd=%0d miss=%0d err=%0d, required %0d %0d %0d",
               rd_cnt, miss_cnt, err_cnt, exp_rd, exp_miss, exp_err);
    else passed++;
  endtask

  task automatic test_reset_mid_req();
    bit acc;
    int waited;
    int reqs;
    for (int i = 0; i < 4; i++) push(4'd0, 32'h0000_5000 + 32'(i * 16), acc);
    waited = 0;
    while (cache_req !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    total++;
    if ({cache_req, busy} !== 2'b11)
      $display("FAIL pre_reset: req/busy=%b, required 11", {cache_req, busy});
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({cache_req, busy, in_ready} !== 3'b001 ||
        {rd_cnt, wr_cnt, hit_cnt, miss_cnt, err_cnt} !== '0)
      $display("FAIL async_reset: req/busy/ready=%b rd=%0d miss=%0d err=%0d, required 001 and counters 0",
               {cache_req, busy, in_ready}, rd_cnt, miss_cnt, err_cnt);
    else passed++;
    sb.delete();
    exp_rd = '0; exp_wr = '0; exp_hit = '0; exp_miss = '0; exp_err = '0;
    tick();
    rst_n = 1'b1;
    reqs = 0;
    repeat (10) begin
      tick();
      if (cache_req === 1'b1) reqs++;
    end
    total++;
    if (reqs !== 0 || busy !== 1'b0)
      $display("FAIL post_reset_quiet: cache_req high %0d cycles busy=%b, required 0 and 0", reqs, busy);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_backpressure();
    test_clear_print();
    test_illegal();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
